// File: rtl/sweep_pkg.sv
// Shared types and constants for the carrier sweep sequencer.
package sweep_pkg;

    localparam int unsigned PHASE_W_DEF = 32;
    localparam int unsigned DWELL_W_DEF = 24;
    localparam int unsigned MODE_W_DEF  = 6;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StLast,
        StDone
    } sweep_state_e;

    localparam logic [5:0] MOD_NONE    = 6'b00_0000;
    localparam logic [5:0] MOD_FM5K    = 6'b01_0101;
    localparam logic [5:0] MOD_FM10K   = 6'b01_1010;
    localparam logic [5:0] MOD_AM_BASE = 6'b10_0000;
    localparam logic [5:0] MOD_PSK     = 6'b11_0000;
    localparam logic [5:0] MOD_ASK     = 6'b11_0001;

endpackage

// File: rtl/sweep_dwell_cnt.sv
// Loadable dwell down-counter; a zero dwell loads as one cycle per point.
module sweep_dwell_cnt #(
    parameter int unsigned DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               dec,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - DWELL_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency sweep sequencer driving freq_c/flag_mod of the sine generator.
// Define SWEEP_DOWN_EN to allow descending sweeps when start > stop.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int unsigned PHASE_W = PHASE_W_DEF,
    parameter int unsigned DWELL_W = DWELL_W_DEF,
    parameter int unsigned MODE_W  = MODE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_start,
    input  logic [PHASE_W-1:0] cfg_stop,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [MODE_W-1:0]  cfg_mode,
    input  logic               cfg_loop,
    input  logic               go,
    input  logic               abort,
    output logic [PHASE_W-1:0] freq_c,
    output logic [MODE_W-1:0]  flag_mod,
    output logic               busy,
    output logic               point_tick,
    output logic               done
);

    sweep_state_e       state_q;
    logic [PHASE_W-1:0] start_q, stop_q, step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [MODE_W-1:0]  mode_q;
    logic               loop_q, have_cfg_q;

    logic               hs, go_ok, expire, cnt_zero, single, clamp;
    logic [PHASE_W-1:0] eff_start, eff_stop, eff_step, nxt;
    logic [DWELL_W-1:0] eff_dwell;
    logic [MODE_W-1:0]  eff_mode;
    logic [PHASE_W:0]   sum;
`ifdef SWEEP_DOWN_EN
    logic               eff_desc;
    logic [PHASE_W:0]   diff;
`endif

    assign hs     = cfg_valid && (state_q == StIdle);
    assign go_ok  = go && (state_q == StIdle) && (have_cfg_q || cfg_valid);
    assign expire = ((state_q == StRun) || (state_q == StLast)) && cnt_zero && !abort;

    // A handshake coinciding with go must feed go the fresh values.
    always_comb begin
        eff_start = hs ? cfg_start : start_q;
        eff_stop  = hs ? cfg_stop  : stop_q;
        eff_step  = hs ? cfg_step  : step_q;
        eff_dwell = hs ? cfg_dwell : dwell_q;
        eff_mode  = hs ? cfg_mode  : mode_q;
        sum       = {1'b0, freq_c} + {1'b0, step_q};
        nxt       = sum[PHASE_W-1:0];
        clamp     = sum[PHASE_W] || (sum[PHASE_W-1:0] >= stop_q);
`ifdef SWEEP_DOWN_EN
        eff_desc  = eff_start > eff_stop;
        single    = (eff_step == '0) || (eff_start == eff_stop);
        diff      = {1'b0, freq_c} - {1'b0, step_q};
        if (eff_desc) begin
            nxt   = diff[PHASE_W-1:0];
            clamp = diff[PHASE_W] || (diff[PHASE_W-1:0] <= stop_q);
        end
`else
        single    = (eff_step == '0) || (eff_start >= eff_stop);
`endif
    end

    sweep_dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (go_ok || expire),
        .dwell (eff_dwell),
        .dec   (busy),
        .zero  (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            freq_c     <= '0;
            flag_mod   <= '0;
            busy       <= 1'b0;
            point_tick <= 1'b0;
            done       <= 1'b0;
            cfg_ready  <= 1'b1;
            start_q    <= '0;
            stop_q     <= '0;
            step_q     <= '0;
            dwell_q    <= '0;
            mode_q     <= '0;
            loop_q     <= 1'b0;
            have_cfg_q <= 1'b0;
        end else begin
            point_tick <= 1'b0;
            done       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (hs) begin
                        start_q    <= cfg_start;
                        stop_q     <= cfg_stop;
                        step_q     <= cfg_step;
                        dwell_q    <= cfg_dwell;
                        mode_q     <= cfg_mode;
                        loop_q     <= cfg_loop;
                        have_cfg_q <= 1'b1;
                    end
                    if (go_ok) begin
                        freq_c     <= eff_start;
                        flag_mod   <= eff_mode;
                        point_tick <= 1'b1;
                        busy       <= 1'b1;
                        cfg_ready  <= 1'b0;
                        state_q    <= single ? StLast : StRun;
                    end
                end
                StRun: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else if (cnt_zero) begin
                        point_tick <= 1'b1;
                        freq_c     <= clamp ? stop_q : nxt;
                        state_q    <= clamp ? StLast : StRun;
                    end
                end
                StLast: begin
                    if (abort || (cnt_zero && !loop_q)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else if (cnt_zero) begin
                        point_tick <= 1'b1;
                        freq_c     <= start_q;
                        state_q    <= single ? StLast : StRun;
                    end
                end
                StDone: begin
                    cfg_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/sweep_ctrl.md
Name: sweep_ctrl

Overview:
Sequencer for the sine generator's carrier DDS and modulation selection. It accepts a sweep configuration through a valid/ready handshake: start, stop, step, dwell and modulation code. On command it steps freq_c from start to stop, holding each frequency for a programmed dwell. It drives freq_c/flag_mod directly into the generator top, replacing the static host-written values.

Parameters:
PHASE_W, 32, width of frequency tuning words (freq_c, start, stop, step)
DWELL_W, 24, width of dwell counter (cycles per frequency point)
MODE_W, 6, width of flag_mod modulation code

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration accepted when cfg_valid&cfg_ready
cfg_start  in  PHASE_W  first tuning word
cfg_stop  in  PHASE_W  last tuning word
cfg_step  in  PHASE_W  tuning-word increment per point
cfg_dwell  in  DWELL_W  cycles per point (0 treated as 1)
cfg_mode  in  MODE_W  modulation code applied during sweep
cfg_loop  in  1  1 = restart at start after stop, until abort
go  in  1  single-cycle pulse, begin sweep
abort  in  1  single-cycle pulse, stop sweep
freq_c  out  PHASE_W  carrier tuning word to generator
flag_mod  out  MODE_W  modulation select to generator
busy  out  1  sweep in progress
point_tick  out  1  one-cycle pulse on each new frequency point
done  out  1  one-cycle pulse at sweep completion or abort

Behaviour:
- Reset: state IDLE; freq_c=0, flag_mod=0, busy=0, point_tick=0, done=0, cfg_ready=1; shadow config registers cleared (cfg_valid flag=0).
- States: IDLE, RUN, LAST, DONE.
- IDLE: cfg_ready=1; a handshake latches all cfg_* into shadow registers and sets the cfg_valid flag. go with no cfg_valid flag is ignored. go with the flag set -> RUN next cycle; freq_c<=start, flag_mod<=mode, dwell counter<=max(dwell,1)-1, point_tick=1, busy=1. A handshake and go in the same cycle: go uses the newly latched values.
- RUN/LAST: cfg_ready=0; cfg_valid is ignored (not consumed). Dwell counter decrements each cycle. At counter==0 in RUN: next = freq_c + step computed at PHASE_W+1 bits. If next>=stop or it carries out, freq_c<=stop and go to LAST; otherwise freq_c<=next and stay in RUN. Either way the counter reloads and point_tick=1.
- A point whose freq_c equals stop (including start>=stop) holds for the full dwell, then goes to DONE. When cfg_loop=1 it instead reloads start (point_tick=1) and returns to RUN.
- step==0: treated as a single point at start, then LAST/DONE behaviour.
- Latency: go -> freq_c valid 1 cycle; each point held exactly max(dwell,1) cycles.
- DONE: one cycle; done=1, busy=0, freq_c/flag_mod hold their last values, cfg flag retained (re-go repeats sweep) -> IDLE.
- abort in RUN/LAST -> DONE next cycle, freq_c held, point_tick suppressed. abort has priority over a dwell expiry in the same cycle. abort in IDLE/DONE: no effect.
- rst mid-sweep: immediate return to reset values next edge; no done pulse.

Optional Feature:
SWEEP_DOWN_EN: when defined, start>stop selects a descending sweep. The next point is freq_c - step computed with borrow. next<=stop or a borrow clamps to stop -> LAST. Direction is latched at handshake. When not defined, start>=stop yields a single point at start (no direction logic synthesized).

Decomposition:
- Shared package sweep_pkg: state enum (IDLE/RUN/LAST/DONE), PHASE_W/DWELL_W/MODE_W defaults, mode code constants (MOD_NONE=6'b00_0000, FM5K=6'b01_0101, FM10K=6'b01_1010, AM base 6'b10_0000, PSK=6'b11_0000, ASK=6'b11_0001).
- One natural sub-module: sweep_dwell_cnt (loadable down-counter with zero flag and max(dwell,1) load).

Test Plan:
- Handshake start=100, stop=130, step=10, dwell=3, mode=6'b01_0101; go -> freq_c 100,110,120,130, each held 3 cycles; 4 point_ticks; done 12 cycles after the first point; flag_mod=6'b01_0101.
- start=100, stop=125, step=10, dwell=1 -> 100,110,120,125 (clamp); done after 4 cycles.
- start=32'hFFFF_FFF0, stop=32'hFFFF_FFFF, step=32 -> carry clamps; points FFFF_FFF0 then FFFF_FFFF; then done.
- cfg_loop=1, start=0, stop=20, step=10, dwell=2 -> 0,10,20,0,10… continues; abort at 2nd point 10 -> done next cycle, freq_c stays 10, busy=0.
- go without a prior handshake -> stays IDLE, busy=0; dwell=0 -> each point held 1 cycle; rst asserted mid-RUN -> freq_c=0, flag_mod=0, no done pulse.
- SWEEP_DOWN_EN defined: start=50, stop=20, step=15, dwell=1 -> 50,35,20, done; undefined: same config -> single point 50, then done.
